msk_state_loader: RTL

- Upstream loader for the masked Clyde state registers.
- Collects a d-share masked 128-bit value from a narrow word stream, one WORD-bit slice of every share per beat, and presents the full d-share state on a valid/ready interface.
- The consuming masked enable-register bank captures the state on the handshake.
- Shares are stored and routed strictly separately; no logic ever combines bits of different shares.

---
 rtl/msk_state_loader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/msk_state_loader.sv
// Collects a d-share masked state from a narrow word stream and presents it on a valid/ready port.
// Shares are written through a common per-slot enable and are never combined with each other.
module msk_state_loader #(
    parameter int d      = 2,
    parameter int WORD   = 32,
    parameter int NWORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      abort,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [d*WORD-1:0]         in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [d*WORD*NWORDS-1:0]  out_state,
    output logic                      busy
);

    localparam int SW = WORD * NWORDS;
    localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CW-1:0]       cnt_r;
    logic [CW-1:0]       cnt_nxt_s;
    logic                accept_s;
    logic [NWORDS-1:0]   wr_en_s;
    logic [d*SW-1:0]     data_r;
    logic                out_valid_r;
    logic                busy_r;

    assign in_ready  = (state_r != ST_FULL);
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_state = data_r;

    // Next-state, word counter and per-slot write enables
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = in_valid & (state_r != ST_FULL);
        wr_en_s     = '0;
        if (abort) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = '0;
        end else begin
            for (int k = 0; k < NWORDS; k++) begin
                wr_en_s[k] = accept_s && (cnt_r == CW'(k));
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (NWORDS == 1) begin
                            state_nxt_s = ST_FULL;
                            cnt_nxt_s   = '0;
                        end else begin
                            state_nxt_s = ST_LOAD;
                            cnt_nxt_s   = CW'(1);
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        if (cnt_r == CW'(NWORDS - 1)) begin
                            state_nxt_s = ST_FULL;
                            cnt_nxt_s   = '0;
                        end else begin
                            cnt_nxt_s = cnt_r + CW'(1);
                        end
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = '0;
                end
            endcase
        end
    end

    // Control registers; status outputs are decoded from the next state so they come straight off flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            out_valid_r <= (state_nxt_s == ST_FULL);
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    // Share storage: each word slot is enabled independently of the data it holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= '0;
        end else begin
            for (int k = 0; k < NWORDS; k++) begin
                if (wr_en_s[k]) begin
                    for (int i = 0; i < d; i++) begin
                        data_r[i*SW + k*WORD +: WORD] <= in_data[i*WORD +: WORD];
                    end
                end
            end
        end
    end

endmodule
